// File: rtl/alm_config_loader_if.sv
// Bitstream word stream between the configuration source (ROM or host FIFO) and the ALM loader.
interface alm_config_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/alm_config_loader.sv
// Serial ALM configuration loader: fetches WORD_W-bit words and shifts NUM_ALMS*BITSTREAM_SIZE bits MSB first.
// Define ALM_CFG_READBACK_EN to add the CRC-16-CCITT recirculating readback check.
module alm_config_loader #(
    parameter int BITSTREAM_SIZE = 87,
    parameter int NUM_ALMS       = 1,
    parameter int WORD_W         = 8,
    parameter int TIMEOUT        = 1024
) (
    input  logic               clk,
    input  logic               clear_sync_n,
    input  logic               start,
    input  logic               abort,
    alm_config_loader_if.slave bs,
    output logic               config_in,
    output logic               config_en,
    input  logic               config_out,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int TOTAL  = NUM_ALMS * BITSTREAM_SIZE;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int WL_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(TOTAL);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
`ifdef ALM_CFG_READBACK_EN
    localparam logic [2:0] ST_VERIFY = 3'd3;
`endif
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [WORD_W-1:0] word_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WL_W-1:0]   word_left_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              config_in_r;
    logic              config_en_r;
    logic              data_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              hs_s;
    logic              last_bit_s;
    logic              word_end_s;
    logic              tmo_hit_s;
    logic              err_set_s;

    assign hs_s       = (state_r == ST_FETCH) && bs.data_valid && data_ready_r;
    assign last_bit_s = (bit_cnt_r == LAST_BIT);
    assign word_end_s = (word_left_r == {WL_W{1'b0}});
    assign tmo_hit_s  = (TIMEOUT != 32'sd0) && (wait_cnt_r == WAIT_LAST);

`ifdef ALM_CFG_READBACK_EN
    logic [15:0] crc_shift_r;
    logic [15:0] crc_vfy_r;
    logic [15:0] crc_vfy_nx_s;
    logic        crc_ok_s;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_vfy_nx_s = crc16_step(crc_vfy_r, config_out);
    assign crc_ok_s     = (crc_vfy_nx_s == crc_shift_r);
    // During readback the chain output is fed straight back so its contents survive.
    assign config_in    = (state_r == ST_VERIFY) ? config_out : config_in_r;
`else
    logic unused_config_out_s;
    assign unused_config_out_s = config_out;
    assign config_in           = config_in_r;
`endif

    assign config_en     = config_en_r;
    assign bs.data_ready = data_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

    // Next-state decode; abort overrides everything except a start from IDLE.
    always_comb begin
        state_nx_s = state_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_FETCH;
                else       state_nx_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (abort)          state_nx_s = ST_IDLE;
                else if (hs_s)      state_nx_s = ST_SHIFT;
                else if (tmo_hit_s) begin
                    state_nx_s = ST_IDLE;
                    err_set_s  = 1'b1;
                end
                else                state_nx_s = ST_FETCH;
            end
            ST_SHIFT: begin
                if (abort)           state_nx_s = ST_IDLE;
`ifdef ALM_CFG_READBACK_EN
                else if (last_bit_s) state_nx_s = ST_VERIFY;
`else
                else if (last_bit_s) state_nx_s = ST_DONE;
`endif
                else if (word_end_s) state_nx_s = ST_FETCH;
                else                 state_nx_s = ST_SHIFT;
            end
`ifdef ALM_CFG_READBACK_EN
            ST_VERIFY: begin
                if (abort)           state_nx_s = ST_IDLE;
                else if (last_bit_s) begin
                    if (crc_ok_s) state_nx_s = ST_DONE;
                    else begin
                        state_nx_s = ST_IDLE;
                        err_set_s  = 1'b1;
                    end
                end
                else                 state_nx_s = ST_VERIFY;
            end
`endif
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!clear_sync_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            data_ready_r <= 1'b0;
            config_en_r  <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            done_r       <= (state_nx_s == ST_DONE);
            data_ready_r <= (state_nx_s == ST_FETCH);
`ifdef ALM_CFG_READBACK_EN
            config_en_r  <= (state_nx_s == ST_SHIFT) || (state_nx_s == ST_VERIFY);
`else
            config_en_r  <= (state_nx_s == ST_SHIFT);
`endif
            if ((state_r == ST_IDLE) && start) error_r <= 1'b0;
            else if (err_set_s)                error_r <= 1'b1;
            else                               error_r <= error_r;
        end
    end

    // Word shifter and bit/word/wait counters; the bit count also times the readback pass.
    always_ff @(posedge clk) begin
        if (!clear_sync_n) begin
            word_r      <= {WORD_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            word_left_r <= {WL_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
            config_in_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (hs_s) begin
                        word_r      <= {bs.data_in[WORD_W-2:0], 1'b0};
                        config_in_r <= bs.data_in[WORD_W-1];
                        bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
                        word_left_r <= WL_W'(WORD_W - 1);
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + WAIT_W'(1);
                        config_in_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    wait_cnt_r <= {WAIT_W{1'b0}};
                    if (!last_bit_s && !word_end_s) begin
                        config_in_r <= word_r[WORD_W-1];
                        word_r      <= {word_r[WORD_W-2:0], 1'b0};
                        bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
                        word_left_r <= word_left_r - WL_W'(1);
                    end else begin
                        config_in_r <= 1'b0;
                        // Restart the count so it can time the readback pass.
                        if (last_bit_s) bit_cnt_r <= CNT_W'(1);
                        else            bit_cnt_r <= bit_cnt_r;
                    end
                end
`ifdef ALM_CFG_READBACK_EN
                ST_VERIFY: bit_cnt_r <= bit_cnt_r + CNT_W'(1);
`endif
                default: begin
                    word_r      <= {WORD_W{1'b0}};
                    bit_cnt_r   <= {CNT_W{1'b0}};
                    word_left_r <= {WL_W{1'b0}};
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                    config_in_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALM_CFG_READBACK_EN
    // CRC over the bits shifted in and over the bits seen coming back out of the chain.
    always_ff @(posedge clk) begin
        if (!clear_sync_n) begin
            crc_shift_r <= 16'hFFFF;
            crc_vfy_r   <= 16'hFFFF;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    crc_shift_r <= 16'hFFFF;
                    crc_vfy_r   <= 16'hFFFF;
                end
                ST_SHIFT:  crc_shift_r <= crc16_step(crc_shift_r, config_in_r);
                ST_VERIFY: crc_vfy_r   <= crc_vfy_nx_s;
                default: begin
                    crc_shift_r <= crc_shift_r;
                    crc_vfy_r   <= crc_vfy_r;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_alm_config_loader.sv
// Randomized scoreboard bench for alm_config_loader: expected chain bits and load outcomes are queued
// by the stimulus and popped by an independent monitor.
module tb_alm_config_loader;
    localparam int BS     = 87;
    localparam int NA     = 1;
    localparam int WORD_W = 8;
    localparam int TMO    = 16;
    localparam int T      = BS * NA;
    localparam int NW     = (T + WORD_W - 1) / WORD_W;

    logic clk = 1'b0;
    logic clear_sync_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic config_in, config_en, config_out, busy, done, error;

    alm_config_loader_if #(.WORD_W(WORD_W)) bs();

    alm_config_loader #(
        .BITSTREAM_SIZE(BS), .NUM_ALMS(NA), .WORD_W(WORD_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .clear_sync_n(clear_sync_n), .start(start), .abort(abort), .bs(bs),
        .config_in(config_in), .config_en(config_en), .config_out(config_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Behavioural ALM chain: a T-bit shift register clocked by config_en.
    logic [T-1:0] chain = '0;
    always @(posedge clk) if (config_en === 1'b1) chain <= {chain[T-2:0], config_in};
    assign config_out = chain[T-1];

    int n_vec = 0;
    int n_err = 0;
    bit bit_q[$];
    bit res_q[$];
    bit mon_on = 1'b0;
    logic err_prev = 1'b0;
    logic [WORD_W-1:0] words [NW];
    logic [T-1:0] exp_vec;
    bit feed_stop, feed_done;
    int feed_limit;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every config_en cycle consumes one expected bit; done / error edges consume an outcome.
    always @(negedge clk) begin
        if (mon_on) begin
            if (config_en === 1'b1) begin
                if (bit_q.size() == 0) fail("extra_config_en_cycle", 1, 0);
                else chk("config_in_bit", config_in, bit_q.pop_front());
            end
            if (done === 1'b1) begin
                if (res_q.size() == 0) fail("unexpected_done", 1, 0);
                else begin
                    chk("outcome_done", 1'b0, res_q.pop_front());
                    chk("bits_left_at_done", bit_q.size(), 0);
                end
            end
            if (error === 1'b1 && err_prev !== 1'b1) begin
                if (res_q.size() == 0) fail("unexpected_error", 1, 0);
                else chk("outcome_error", 1'b1, res_q.pop_front());
            end
        end
        err_prev = error;
    end

    task automatic feeder(input int lo, input int hi);
        for (int k = 0; k < feed_limit && !feed_stop; k++) begin
            int g;
            g = $urandom_range(hi, lo);
            bs.data_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            bs.data_in    = words[k];
            bs.data_valid = 1'b1;
            for (int c = 0; c < 300 && !feed_stop; c++) begin
                bit r;
                @(negedge clk);
                r = bs.data_ready;
                @(posedge clk);
                #1;
                if (r) break;
            end
        end
        bs.data_valid = 1'b0;
        feed_done     = 1'b1;
    endtask

    // wmode: 0 random words, 1 all 0xA5, 2 reuse previous words.
    // ev_kind: 0 plain, 1 abort at ev_bit, 2 reset at ev_bit, 3 start while busy at ev_bit,
    //          4 withhold data after ev_bit words.
    task automatic do_load(input int wmode, input int gap_lo, input int gap_hi,
                           input int ev_kind, input int ev_bit, input bit with_abort);
        int nb, en_k, idle_rdy;
        bit fired, ended;
        for (int k = 0; k < NW; k++) begin
            if (wmode == 0)      words[k] = WORD_W'($urandom);
            else if (wmode == 1) words[k] = 8'hA5;
        end
        for (int i = 0; i < T; i++) exp_vec[T-1-i] = words[i / WORD_W][WORD_W-1-(i % WORD_W)];
        nb = (ev_kind == 1 || ev_kind == 2) ? ev_bit : (ev_kind == 4) ? ev_bit * WORD_W : T;
        for (int i = 0; i < nb; i++) bit_q.push_back(exp_vec[T-1-i]);
        if (ev_kind == 0 || ev_kind == 3) res_q.push_back(1'b0);
        else if (ev_kind == 4)            res_q.push_back(1'b1);
        feed_limit = (ev_kind == 4) ? ev_bit : NW;
        feed_stop  = 1'b0;
        feed_done  = 1'b0;

        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        fork
            feeder(gap_lo, gap_hi);
        join_none
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
        chk("error_cleared_by_start", error, 1'b0);

        en_k = 0; idle_rdy = 0; fired = 1'b0; ended = 1'b0;
        for (int c = 0; c < 4000 && !ended; c++) begin
            @(negedge clk);
            if (config_en === 1'b1) en_k++;
            if (feed_done && bs.data_ready === 1'b1 && bs.data_valid !== 1'b1) idle_rdy++;
            if (busy !== 1'b1) ended = 1'b1;
            else if (!fired && ev_kind inside {1, 2, 3} && en_k == ev_bit) begin
                fired = 1'b1;
                case (ev_kind)
                    1:       abort = 1'b1;
                    2:       clear_sync_n = 1'b0;
                    default: start = 1'b1;
                endcase
                @(posedge clk); #1;
                abort = 1'b0;
                clear_sync_n = 1'b1;
                start = 1'b0;
                if (ev_kind != 3) begin
                    @(negedge clk);
                    chk("cut_config_en", config_en, 1'b0);
                    chk("cut_busy", busy, 1'b0);
                    chk("cut_done", done, 1'b0);
                    chk("cut_data_ready", bs.data_ready, 1'b0);
                    if (ev_kind == 2) begin
                        chk("reset_config_in", config_in, 1'b0);
                        chk("reset_error", error, 1'b0);
                    end
                    ended = 1'b1;
                end
            end
        end
        if (!ended) fail("load_hang", 0, 1);
        feed_stop = 1'b1;
        wait (feed_done);
        bs.data_valid = 1'b0;
        @(negedge clk);
        chk("bits_left", bit_q.size(), 0);
        chk("outcomes_left", res_q.size(), 0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_config_en", config_en, 1'b0);
        chk("idle_data_ready", bs.data_ready, 1'b0);
        chk("idle_error", error, (ev_kind == 4) ? 1'b1 : 1'b0);
        if (ev_kind == 0 || ev_kind == 3) chk("chain_contents", chain, exp_vec);
        if (ev_kind == 4) chk("timeout_wait_cycles", idle_rdy, TMO);
        bit_q.delete();
        res_q.delete();
    endtask

    initial begin
        bs.data_in    = '0;
        bs.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_config_en", config_en, 1'b0);
        chk("rst_config_in", config_in, 1'b0);
        chk("rst_data_ready", bs.data_ready, 1'b0);
        clear_sync_n = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;

        do_load(1, 0, 0, 0, 0, 1'b0);   // 0xA5 pattern, gapless
        do_load(0, 0, 0, 0, 0, 1'b0);   // random words, gapless
        do_load(2, 5, 5, 0, 0, 1'b0);   // same words with 5-cycle back-pressure
        do_load(0, 0, 3, 1, 40, 1'b0);  // abort after 40 bits
        do_load(0, 0, 2, 0, 0, 1'b0);   // full load after abort
        do_load(0, 0, 1, 4, 3, 1'b0);   // timeout after 3 words
        do_load(0, 0, 0, 0, 0, 1'b1);   // start+abort in IDLE; start clears error
        do_load(0, 1, 2, 2, 50, 1'b0);  // reset at bit 50
        do_load(0, 0, 2, 0, 0, 1'b0);   // full load after reset
        do_load(0, 0, 2, 3, 20, 1'b0);  // start while busy is ignored
        for (int n = 0; n < 3; n++) do_load(0, 0, 4, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alm_config_loader.md
Name: alm_config_loader

Overview:
- Controller that serially configures one ALM, or a daisy-chain of ALMs, through the `config_in`/`config_en`/`config_out` shift chain.
- Fetches the bitstream as `WORD_W`-bit words over a valid/ready stream and shifts exactly `NUM_ALMS*BITSTREAM_SIZE` bits, MSB first.
- Reports busy, done and error status.
- Sits between the bitstream source (ROM or host FIFO) and the ALM array. The ALM `config_clk` is tied to `clk`.

Parameters:
- `BITSTREAM_SIZE`, 87, config bits per ALM (86 + XOR6 bit with XOR6 enabled, MajAdd disabled).
- `NUM_ALMS`, 1, ALMs daisy-chained (`config_out` to next `config_in`).
- `WORD_W`, 8, bitstream word width.
- `TIMEOUT`, 1024, max cycles waiting for `data_valid` in FETCH; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock for controller and config chain.
- `clear_sync_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored while busy.
- `abort`  in  1  cancel the load in progress.
- `data_in`  in  `WORD_W`  bitstream word; MSB is shifted first.
- `data_valid`  in  1  word valid.
- `data_ready`  out  1  loader accepts a word.
- `config_in`  out  1  serial bit to the ALM chain.
- `config_en`  out  1  chain shift enable.
- `config_out`  in  1  serial output of the last ALM in the chain.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky error flag; cleared by an accepted `start`.

Behaviour:
- Reset (`clear_sync_n`=0 at a `clk` edge):
  - State goes to IDLE.
  - `data_ready`, `config_in`, `config_en`, `busy`, `done`, `error` all = 0.
  - Counters = 0.
  - Chain contents are undefined after reset mid-load.
- Sizing:
  - T = `NUM_ALMS*BITSTREAM_SIZE`.
  - W = ceil(T/`WORD_W`) words per load.
  - Bit counter width = clog2(T+1).
  - Defaults: T=87, W=11. The last word supplies bits 7..1 only; bit 0 is discarded.
- States: IDLE, FETCH, SHIFT, VERIFY (macro only), DONE.
- IDLE:
  - `start`=1 leads to FETCH next cycle, with `busy`=1 and `error` cleared.
- FETCH:
  - `data_ready`=1.
  - On `data_valid`&`data_ready` the word is latched and the state goes to SHIFT.
  - Wait counter increments each cycle without valid. Reaching `TIMEOUT` (if nonzero) sets `error`=1 and returns to IDLE; `done` is not pulsed.
- SHIFT:
  - Registered outputs: the cycle after the handshake, `config_en`=1 and `config_in`=word bit `WORD_W`-1; then descending bits, one per cycle.
  - After the last bit of a word: FETCH if bits remain. `config_en`=0 during FETCH; gaps are legal and the chain holds.
  - After bit T: DONE (or VERIFY with the macro).
  - `config_en` is high for exactly T cycles per successful load.
- DONE:
  - `config_en`=0 and `done`=1 for one cycle.
  - Next cycle: IDLE, `busy`=0.
- `abort`:
  - In any non-IDLE state, IDLE is entered next cycle with `config_en`=0, `data_ready`=0, `busy`=0, no `done`.
  - `error` is unchanged. A partially accepted word is dropped.
- Simultaneous events:
  - `start`+`abort` in IDLE: `start` wins.
  - `abort` with the final handshake: `abort` wins.
  - `start` while busy: ignored.
- `data_ready` is deasserted in all states except FETCH.

Optional Feature:
- Macro `ALM_CFG_READBACK_EN`.
- Enabled:
  - During SHIFT the loader accumulates a bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the bits shifted in.
  - SHIFT then goes to VERIFY for T cycles with `config_en`=1 and `config_in`=`config_out` (combinational recirculation), so chain contents are preserved.
  - In VERIFY, a second CRC is computed over sampled `config_out`.
  - At the end: match leads to DONE; mismatch sets `error`=1 and returns to IDLE without `done`.
  - Total `config_en`-high cycles = 2T.
- Disabled: no VERIFY state, no CRC logic; `config_out` is unused.

Test Plan:
- Basic load, defaults: `start`, 11 words 0xA5 with `data_valid` held 1 → 87 `config_en` cycles; `config_in` sequence 1,0,1,0,0,1,0,1 repeating; the last word contributes 7 bits; `done` pulses once; the downstream ALM computes C6:111 (`out_0`/`out_2` = popcount bits 0/1 of A..F over 100 random vectors).
- Back-pressure: `data_valid` low for 5 cycles before each word → `config_en` gaps of ≥5 cycles; total `config_en`-high count still 87; chain contents identical to the gapless load.
- Abort: assert `abort` when 40 bits have been shifted → next cycle `config_en`=0, `busy`=0, `done` never pulses; `error`=0; a subsequent `start` performs a full 87-bit load.
- Timeout: `TIMEOUT`=16, withhold `data_valid` after word 3 → `error`=1 at the 16th wait cycle, IDLE, `busy`=0, `done`=0.
- Reset mid-load: `clear_sync_n`=0 for 1 cycle at bit 50 → all outputs 0 at the following edge; `start` afterwards loads correctly.
- Readback (macro on, `NUM_ALMS`=2, T=174): real chain → `done`, `error`=0, 348 `config_en` cycles; with `config_out` forced to 0 → `error`=1, no `done`.
